// File: rtl/rs232_recv.sv
// rs232_recv: 8N1 serial receiver with 2-flop input synchronizer, 4-entry
// output FIFO and registered active-low CTS flow control.  Rev 1.0
`default_nettype none

module rs232_recv #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 12000000,
  parameter int DIV        = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rs232_txd,
  output logic       rs232_ctsn,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] C_FULL_LOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF_LOAD = CW'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          sync1_q, rxs_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          push, ferr;

  logic [7:0]    mem_q [4];
  logic [1:0]    wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q, count_d;
  logic          ctsn_q, frame_error_q, overrun_q;
  logic          pop, full, wr_en, ovr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rs232_txd;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // A single down-counter times every wait; expiry is the cycle it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = C_HALF_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = S_DATA;
            cnt_d   = C_FULL_LOAD;
            idx_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shreg_d[idx_q] = rxs_q;
          cnt_d          = C_FULL_LOAD;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid = (count_q != 3'd0);
  assign data  = mem_q[rd_ptr_q];
  assign pop   = valid && ready;
  assign full  = (count_q == 3'd4);
  // When full, a simultaneous pop frees the slot the new byte overwrites.
  assign wr_en = push && (!full || pop);
  assign ovr   = push && full && !pop;

  always_comb begin
    count_d = count_q + {2'b00, wr_en} - {2'b00, pop};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
      wr_ptr_q      <= 2'd0;
      rd_ptr_q      <= 2'd0;
      count_q       <= 3'd0;
      ctsn_q        <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shreg_d;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q       <= count_d;
      ctsn_q        <= (count_d >= 3'd2);
      frame_error_q <= ferr;
      overrun_q     <= ovr;
    end
  end

  assign rs232_ctsn  = ctsn_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_rs232_recv.sv
// tb_rs232_recv: directed plus randomized bench for rs232_recv against a
// byte-queue reference model.  Rev 1.0
`default_nettype none

module tb_rs232_recv;

  localparam int C_DIV = 11;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       rs232_txd = 1'b1;
  logic       rs232_ctsn;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic       frame_error;
  logic       overrun;

  rs232_recv dut (
    .clock       (clock),
    .resetn      (resetn),
    .rs232_txd   (rs232_txd),
    .rs232_ctsn  (rs232_ctsn),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vcyc   = 0;
  logic       rs_valid, rs_cts, rs_fe, rs_ov;
  logic [7:0] rs_data;

  // Consumer side of the reference: every handshake delivers one byte.
  always @(negedge clock) begin
    if (resetn) begin
      if (valid && ready) got_q.push_back(data);
      if (valid) vcyc++;
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Drives one 8N1 frame; the stop bit level is held for stop_len clocks.
  task automatic send(input logic [7:0] b, input int stop_len, input logic stop_val,
                      input int pop_at, input int rst_at, input bit rnd_ready,
                      output int lat);
    int total;
    logic prev;
    lat   = -1;
    prev  = valid;
    total = ((10 * C_DIV > 9 * C_DIV + stop_len) ? 10 * C_DIV : 9 * C_DIV + stop_len) + 4;
    tick();
    rs232_txd = 1'b0;
    for (int n = 1; n <= total; n++) begin
      tick();
      if (!prev && valid && lat < 0) lat = n;
      prev = valid;
      if (n == rst_at) resetn = 1'b0;
      if (n == rst_at + 1) begin
        rs_valid = valid; rs_data = data; rs_cts = rs232_ctsn;
        rs_fe = frame_error; rs_ov = overrun;
      end
      if (n == rst_at + 2) resetn = 1'b1;
      if (n == pop_at) ready = 1'b1;
      if (n == pop_at + 1) ready = 1'b0;
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      if (n < 9 * C_DIV) begin
        if (n / C_DIV == 0) rs232_txd = 1'b0;
        else rs232_txd = b[n / C_DIV - 1];
      end else if (n < 9 * C_DIV + stop_len) begin
        rs232_txd = stop_val;
      end else begin
        rs232_txd = 1'b1;
      end
    end
  endtask

  task automatic send_ok(input logic [7:0] b, input bit rnd_ready);
    int l;
    send(b, C_DIV, 1'b1, -10, -10, rnd_ready, l);
  endtask

  initial begin
    int lat0, lat1, lat_dummy, fe0, ov0, v0;
    logic [7:0] b;

    repeat (3) tick();
    check("rst_valid", valid, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_ctsn", rs232_ctsn, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    resetn = 1'b1;
    repeat (5) tick();

    // Single byte, ready always high
    ready = 1'b1;
    v0 = vcyc;
    send(8'hA5, C_DIV, 1'b1, -10, -10, 1'b0, lat0);
    exp_q.push_back(8'hA5);
    repeat (5) tick();
    check("a5_valid_cycles", vcyc - v0, 1);
    check("a5_ferr", fe_cnt, 0);
    check("a5_ovr", ov_cnt, 0);
    check("a5_lat_in_stop", (lat0 > 9 * C_DIV && lat0 <= 10 * C_DIV + 2), 1'b1);
    check_rx("a5");

    // Short glitch on an idle line
    tick(); rs232_txd = 1'b0;
    repeat (3) tick();
    rs232_txd = 1'b1;
    repeat (30) tick();
    check("glitch_ferr", fe_cnt, 0);
    check("glitch_valid", valid, 1'b0);
    check_rx("glitch");

    // Stop bit held low, then a good byte
    fe0 = fe_cnt;
    send(8'h3C, 30, 1'b0, -10, -10, 1'b0, lat_dummy);
    repeat (5) tick();
    check("brk_ferr_pulses", fe_cnt - fe0, 1);
    check_rx("brk_no_byte");
    send_ok(8'h55, 1'b0);
    exp_q.push_back(8'h55);
    repeat (5) tick();
    check_rx("after_brk");

    // Fill with ready low, overflow on the fifth byte
    ready = 1'b0;
    ov0 = ov_cnt;
    send_ok(8'h01, 1'b0);
    check("cts_after1", rs232_ctsn, 1'b0);
    send_ok(8'h02, 1'b0);
    check("cts_after2", rs232_ctsn, 1'b1);
    send_ok(8'h03, 1'b0);
    send_ok(8'h04, 1'b0);
    send_ok(8'h05, 1'b0);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("full_head_valid", valid, 1'b1);
    check("full_head_data", data, 8'h01);
    ready = 1'b1;
    repeat (8) tick();
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    check_rx("drain");
    check("drained_valid", valid, 1'b0);
    check("drained_cts", rs232_ctsn, 1'b0);

    // Full FIFO with push and pop landing on the same cycle
    ready = 1'b0;
    send(8'h10, C_DIV, 1'b1, -10, -10, 1'b0, lat1);
    check("latency_deterministic", lat1, lat0);
    send_ok(8'h11, 1'b0);
    send_ok(8'h12, 1'b0);
    send_ok(8'h13, 1'b0);
    ov0 = ov_cnt;
    send(8'h14, C_DIV, 1'b1, lat1 - 1, -10, 1'b0, lat_dummy);
    check("pp_no_ovr", ov_cnt - ov0, 0);
    check("pp_head", data, 8'h11);
    check("pp_cts", rs232_ctsn, 1'b1);
    ready = 1'b1;
    repeat (8) tick();
    for (int i = 0; i <= 4; i++) exp_q.push_back(8'(8'h10 + i));
    check_rx("pp_order");

    // Randomized traffic with a random consumer
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      send_ok(b, 1'b1);
      exp_q.push_back(b);
      ready = 1'b1;
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (8) tick();
    check_rx("random");

    // Reset in the middle of a frame
    ready = 1'b0;
    send_ok(8'h77, 1'b0);
    send(8'hFF, C_DIV, 1'b1, -10, 5 * C_DIV + C_DIV / 2, 1'b0, lat_dummy);
    check("midrst_valid", rs_valid, 1'b0);
    check("midrst_data", rs_data, 8'h00);
    check("midrst_cts", rs_cts, 1'b0);
    check("midrst_ferr", rs_fe, 1'b0);
    check("midrst_ovr", rs_ov, 1'b0);
    check("postrst_valid", valid, 1'b0);
    ready = 1'b1;
    send_ok(8'h81, 1'b0);
    exp_q.push_back(8'h81);
    repeat (5) tick();
    check_rx("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rs232_recv.md
RS232_RECV -- requirements
Module: rs232_recv

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 133000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 12000000, meaning serial bit rate in baud.
REQ-003 SHALL have parameter DIV, default CLOCK_FREQ/BAUD_RATE rounded to nearest (11 at defaults), meaning clocks per bit; minimum legal value 4.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 rs232_txd  input  1  asynchronous serial line from host; idle high; 8N1, LSB first.
REQ-007 rs232_ctsn  output  1  flow control to host, active low; 0 = host may send.
REQ-008 data  output  8  received byte at FIFO head.
REQ-009 valid  output  1  data holds a byte.
REQ-010 ready  input  1  consumer accepts data this cycle.
REQ-011 frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun  output  1  one-cycle pulse: good byte dropped because FIFO full.

Function
REQ-013 SHALL pass rs232_txd through a 2-flop synchronizer reset to 1; the FSM uses only the synchronized value (rxs).
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK with one bit counter (0..DIV-1) and a 3-bit data index.
REQ-015 IDLE: on rxs==0 SHALL go to START and load the counter for a wait of DIV/2 (integer division) clocks.
REQ-016 START: at counter expiry SHALL sample rxs; 0 -> DATA with a full-DIV wait; 1 -> IDLE (glitch rejected, no pulse).
REQ-017 DATA: each DIV-clock expiry SHALL shift rxs into bit[index], LSB first; after index 7 go to STOP with a full-DIV wait.
REQ-018 STOP: at expiry, rxs==1 SHALL push the byte into the FIFO and return to IDLE; rxs==0 SHALL pulse frame_error, discard the byte, enter BREAK.
REQ-019 BREAK: SHALL stay until rxs==1, then IDLE; no bytes or pulses generated meanwhile.
REQ-020 Line-to-valid latency SHALL be deterministic: valid rises 1 clock after the stop-bit sample cycle when FIFO was empty.
REQ-021 SHALL contain a 4-entry FIFO with 3-bit occupancy count; data/valid show the head combinationally from registered storage.
REQ-022 Pop SHALL occur exactly on cycles with valid && ready; ready while !valid SHALL have no effect.
REQ-023 Push and pop in the same cycle SHALL both take effect; count unchanged; legal also when full.
REQ-024 Push when count==4 and no simultaneous pop SHALL drop the new byte, pulse overrun, keep contents intact.
REQ-025 Read/write pointers SHALL be 2-bit and wrap 3 -> 0 silently.
REQ-026 rs232_ctsn SHALL be registered: 1 when count (after this cycle's update) >= 2, else 0, giving the host two bytes of slack.
REQ-027 data and valid SHALL stay stable while valid && !ready.

Reset
REQ-028 While resetn==0: state IDLE, counters 0, FIFO empty, pointers 0, valid 0, data 8'h00, rs232_ctsn 0, frame_error 0, overrun 0, synchronizer 1.
REQ-029 Deassertion of resetn mid-frame SHALL discard the partial byte; reception resumes at the next falling edge seen in IDLE.
REQ-030 Reset assertion SHALL take effect without a clock edge.

Verification
REQ-031 Defaults, ready=1, send 0xA5 8N1 at 11 clocks/bit -> one valid cycle with data 0xA5; frame_error 0, overrun 0.
REQ-032 Low pulse of 3 clocks on idle line -> no valid, no frame_error, FSM back in IDLE.
REQ-033 Send 0x3C with stop bit held low 30 clocks -> one frame_error pulse, no valid; next byte 0x55 received correctly.
REQ-034 ready=0, send 0x01..0x05 -> rs232_ctsn 1 after 2nd byte; FIFO holds 01..04; overrun pulses once on 0x05; ready=1 pops 01,02,03,04 in order.
REQ-035 FIFO full, push and pop same cycle -> count stays 4, no overrun, order preserved.
REQ-036 resetn low during data bit 4 of 0xFF, release, send 0x81 -> only 0x81 appears; outputs at reset values while resetn==0.
